pio_write_master: RTL

- Avalon-MM initiator that drives 8-bit PIO output slaves, such as the LED/PWM output ports, from a simple valid/ready command interface.
- Issues one write per command, with an optional read-back verify, and honours waitrequest.
- Bounds every bus access with a timeout counter and reports done, mismatch and timeout status.
- Sits between the vending-machine control logic and the PIO slaves, so no soft CPU is needed for LED updates.

---
 rtl/pio_write_master.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pio_write_master.sv
// Avalon-MM write initiator for 8-bit PIO slaves: one write per command with optional
// read-back verify, waitrequest handling and a per-access stall timeout.
module pio_write_master #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              cmd_verify,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest,
    output logic              done,
    output logic              mismatch,
    output logic              timeout,
    output logic [DATA_W-1:0] rd_data
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    // Abort happens on the stalled cycle where the counter already equals LIMIT,
    // so the counter can never run past it.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    state_t            state, state_nxt;
    logic [7:0]        cnt, cnt_nxt;
    logic              verify_q, verify_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              cs_nxt, wn_nxt;
    logic [DATA_W-1:0] wd_nxt, rd_nxt;
    logic              mis_nxt, to_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            verify_q       <= 1'b0;
            avm_address    <= '0;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            mismatch       <= 1'b0;
            timeout        <= 1'b0;
            rd_data        <= '0;
        end else begin
            state          <= state_nxt;
            cnt            <= cnt_nxt;
            verify_q       <= verify_nxt;
            avm_address    <= addr_nxt;
            avm_chipselect <= cs_nxt;
            avm_write_n    <= wn_nxt;
            avm_writedata  <= wd_nxt;
            mismatch       <= mis_nxt;
            timeout        <= to_nxt;
            rd_data        <= rd_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        verify_nxt = verify_q;
        addr_nxt   = avm_address;
        cs_nxt     = avm_chipselect;
        wn_nxt     = avm_write_n;
        wd_nxt     = avm_writedata;
        mis_nxt    = mismatch;
        to_nxt     = timeout;
        rd_nxt     = rd_data;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    addr_nxt   = cmd_addr;
                    wd_nxt     = cmd_data;
                    verify_nxt = cmd_verify;
                    cs_nxt     = 1'b1;
                    wn_nxt     = 1'b0;
                    cnt_nxt    = '0;
                    mis_nxt    = 1'b0;
                    to_nxt     = 1'b0;
                    state_nxt  = WRITE;
                end
            end
            WRITE, READ: begin
                if (!avm_waitrequest) begin
                    if (state == WRITE && verify_q) begin
                        wn_nxt    = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = READ;
                    end else begin
                        // avm_writedata still holds the commanded value for the compare
                        if (state == READ) begin
                            rd_nxt  = avm_readdata;
                            mis_nxt = (avm_readdata != avm_writedata);
                        end
                        cs_nxt    = 1'b0;
                        wn_nxt    = 1'b1;
                        state_nxt = DONE;
                    end
                end else if (cnt == LIMIT) begin
                    cs_nxt    = 1'b0;
                    wn_nxt    = 1'b1;
                    to_nxt    = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign done      = (state == DONE);

endmodule
